// File: rtl/norm_seq_div.sv
// Row normaliser: publishes |row sum|, waits for the sibling sum, then divides
// every element by the combined sum on one shared restoring divider. Option: NORM_SAT_EN.
module norm_seq_div #(
  parameter int BW      = 8,
  parameter int BW_PSUM = 2*BW+4,
  parameter int COL     = 8,
  parameter int FRAC    = 8,
  parameter int SUMW    = BW_PSUM+4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BW_PSUM*COL-1:0]   in,
  output logic [SUMW-1:0]          sum_out,
  output logic                     sum_out_valid,
  input  logic [SUMW-1:0]          sum_in,
  input  logic                     sum_in_valid,
  output logic [BW_PSUM*COL-1:0]   out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int N  = BW_PSUM + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam int KW = $clog2(COL);

  typedef enum logic [2:0] {
    S_IDLE, S_SUM, S_WAIT, S_DIV, S_OUT
  } state_e;

  state_e state_q, state_d;

  logic signed [BW_PSUM-1:0] mem_q  [COL];
  logic [BW_PSUM-1:0]        omem_q [COL];
  logic [SUMW-1:0]           sum_out_q;
  logic                      sum_out_valid_q;
  logic [SUMW-1:0]           sin_q;
  logic                      flag_q;
  logic [SUMW-1:0]           total_q;
  logic [SUMW-1:0]           rem_q;
  logic [N-1:0]              dvd_q;
  logic [N-1:0]              quo_q;
  logic [CW-1:0]             bit_q;
  logic [KW-1:0]             k_q;
  logic                      out_valid_q;

  logic [SUMW-1:0]           local_sum;
  logic [SUMW-1:0]           abs_sum;
  logic                      flag_eff;
  logic [SUMW-1:0]           sin_eff;
  logic [SUMW-1:0]           total_d;
  logic [KW-1:0]             nxt_k;
  logic signed [BW_PSUM-1:0] nel;
  logic [BW_PSUM-1:0]        mag_nxt;
  logic [N-1:0]              dvd_ld;
  logic [SUMW:0]             rem_sh;
  logic                      ge;
  logic [SUMW-1:0]           rem_n;
  logic [N-1:0]              quo_n;
  logic [BW_PSUM-1:0]        q_lo;
  logic                      cur_neg;
  logic [BW_PSUM-1:0]        res;
  logic                      last_bit;
  logic                      last_k;

  always_comb begin
    local_sum = '0;
    for (int k = 0; k < COL; k++) begin
      local_sum = local_sum +
        {{(SUMW-BW_PSUM){mem_q[k][BW_PSUM-1]}}, mem_q[k]};
    end
    abs_sum = local_sum[SUMW-1] ? -local_sum : local_sum;
  end

  // A pulse arriving in WAIT is used in the same cycle.
  always_comb begin
    flag_eff = flag_q | sum_in_valid;
    sin_eff  = sum_in_valid ? sum_in : sin_q;
    total_d  = sum_out_q + sin_eff;
  end

  always_comb begin
    nxt_k   = (state_q == S_WAIT) ? '0 : k_q + KW'(1);
    nel     = mem_q[nxt_k];
    mag_nxt = nel[BW_PSUM-1] ? -nel : nel;
    dvd_ld  = N'(mag_nxt) << FRAC;
  end

  always_comb begin
    rem_sh   = {rem_q, dvd_q[N-1]};
    ge       = rem_sh >= {1'b0, total_q};
    rem_n    = ge ? rem_sh[SUMW-1:0] - total_q : rem_sh[SUMW-1:0];
    quo_n    = {quo_q[N-2:0], ge};
    q_lo     = quo_n[BW_PSUM-1:0];
    cur_neg  = mem_q[k_q][BW_PSUM-1];
    last_bit = bit_q == CW'(N-1);
    last_k   = k_q == KW'(COL-1);
  end

`ifdef NORM_SAT_EN
  logic ovf;
  always_comb begin
    ovf = |quo_n[N-1:BW_PSUM-1];
    if (ovf)
      res = cur_neg ? {1'b1, {(BW_PSUM-1){1'b0}}}
                    : {1'b0, {(BW_PSUM-1){1'b1}}};
    else
      res = cur_neg ? -q_lo : q_lo;
  end
`else
  always_comb begin
    res = cur_neg ? -q_lo : q_lo;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_SUM;
      S_SUM:  state_d = S_WAIT;
      S_WAIT: if (flag_eff)
                state_d = (total_d == '0) ? S_OUT : S_DIV;
      S_DIV:  if (last_bit && last_k) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < COL; k++) begin
        mem_q[k]  <= '0;
        omem_q[k] <= '0;
      end
      sum_out_q       <= '0;
      sum_out_valid_q <= 1'b0;
      sin_q           <= '0;
      flag_q          <= 1'b0;
      total_q         <= '0;
      rem_q           <= '0;
      dvd_q           <= '0;
      quo_q           <= '0;
      bit_q           <= '0;
      k_q             <= '0;
      out_valid_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        for (int k = 0; k < COL; k++)
          mem_q[k] <= in[BW_PSUM*k +: BW_PSUM];
      end
      sum_out_valid_q <= state_q == S_SUM;
      if (state_q == S_SUM) sum_out_q <= abs_sum;
      if ((state_q == S_SUM || state_q == S_WAIT) && sum_in_valid) begin
        flag_q <= 1'b1;
        sin_q  <= sum_in;
      end
      if (state_q == S_WAIT && flag_eff) begin
        flag_q  <= 1'b0;
        total_q <= total_d;
        for (int k = 0; k < COL; k++) omem_q[k] <= '0;
        dvd_q   <= dvd_ld;
        rem_q   <= '0;
        quo_q   <= '0;
        bit_q   <= '0;
        k_q     <= '0;
      end
      if (state_q == S_DIV) begin
        if (last_bit) begin
          omem_q[k_q] <= res;
          k_q   <= k_q + KW'(1);
          bit_q <= '0;
          rem_q <= '0;
          quo_q <= '0;
          dvd_q <= dvd_ld;
        end else begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          dvd_q <= dvd_q << 1;
          bit_q <= bit_q + CW'(1);
        end
      end
      out_valid_q <= state_d == S_OUT;
    end
  end

  always_comb begin
    in_ready = state_q == S_IDLE;
    busy     = state_q != S_IDLE;
    out      = '0;
    if (out_valid_q) begin
      for (int k = 0; k < COL; k++)
        out[BW_PSUM*k +: BW_PSUM] = omem_q[k];
    end
  end

  assign out_valid     = out_valid_q;
  assign sum_out       = sum_out_q;
  assign sum_out_valid = sum_out_valid_q;

endmodule

// File: tb/tb_norm_seq_div.sv
// Directed bench for norm_seq_div: sums, quotients, latency,
// back-pressure and mid-row reset.
module tb_norm_seq_div;

  localparam int BW      = 8;
  localparam int BW_PSUM = 2*BW+4;
  localparam int COL     = 8;
  localparam int FRAC    = 8;
  localparam int SUMW    = BW_PSUM+4;
  localparam int W       = BW_PSUM*COL;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_d;
  logic [SUMW-1:0] sum_out;
  logic            sum_out_valid;
  logic [SUMW-1:0] sum_in;
  logic            sum_in_valid;
  logic [W-1:0]    out_d;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  norm_seq_div #(
    .BW(BW), .BW_PSUM(BW_PSUM), .COL(COL), .FRAC(FRAC), .SUMW(SUMW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_d),
    .sum_out(sum_out), .sum_out_valid(sum_out_valid),
    .sum_in(sum_in), .sum_in_valid(sum_in_valid),
    .out(out_d), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  function automatic logic [W-1:0] row2(input int a, input int b,
                                        input int r);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < COL; k++)
      v[k*BW_PSUM +: BW_PSUM] = BW_PSUM'(k == 0 ? a : (k == 1 ? b : r));
    return v;
  endfunction

  // Drives one row and a sibling pulse; returns observations only.
  task automatic drive_row(input logic [W-1:0] row,
                           input logic [SUMW-1:0] sin,
                           output logic [SUMW-1:0] so,
                           output int so_lat, output int out_lat);
    so_lat  = -1;
    out_lat = -1;
    @(negedge clk);
    in_d = row;
    in_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (sum_out_valid) begin
        so_lat = n;
        break;
      end
    end
    so = sum_out;
    sum_in = sin;
    sum_in_valid = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      sum_in_valid = 1'b0;
      if (out_valid) begin
        out_lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 6;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    if (sum_out !== '0) begin
      n_err++; $display("FAIL rst_sum_out got %0d want 0", sum_out);
    end
    if (sum_out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_sum_out_valid got %b want 0", sum_out_valid);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy got %b want 0", busy);
    end
    if (out_d !== '0) begin
      n_err++; $display("FAIL rst_out got %h want 0", out_d);
    end
    reset = 1'b0;
  endtask

  task automatic test_uniform;
    logic [SUMW-1:0] so;
    logic [W-1:0] exp_o;
    int sl, ol;
    exp_o = row2(32, 32, 32);
    drive_row(row2(16, 16, 16), 0, so, sl, ol);
    n_cmp += 4;
    if (sl !== 2) begin
      n_err++; $display("FAIL uni_sum_lat got %0d want 2", sl);
    end
    if (so !== 24'd128) begin
      n_err++; $display("FAIL uni_sum_out got %0d want 128", so);
    end
    if (ol !== 225) begin
      n_err++; $display("FAIL uni_out_lat got %0d want 225", ol);
    end
    if (out_d !== exp_o) begin
      n_err++; $display("FAIL uni_out got %h want %h", out_d, exp_o);
    end
    @(negedge clk);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL uni_ov_drop got %b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL uni_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_mixed;
    logic [SUMW-1:0] so;
    logic [W-1:0] exp_o;
    int sl, ol;
    exp_o = row2(256, -128, 0);
    drive_row(row2(100, -50, 0), 50, so, sl, ol);
    n_cmp += 3;
    if (so !== 24'd50) begin
      n_err++; $display("FAIL mix_sum_out got %0d want 50", so);
    end
    if (ol !== 225) begin
      n_err++; $display("FAIL mix_out_lat got %0d want 225", ol);
    end
    if (out_d !== exp_o) begin
      n_err++; $display("FAIL mix_out got %h want %h", out_d, exp_o);
    end
    @(negedge clk);
  endtask

  task automatic test_zero;
    logic [SUMW-1:0] so;
    int sl, ol;
    drive_row(row2(0, 0, 0), 0, so, sl, ol);
    n_cmp += 3;
    if (so !== '0) begin
      n_err++; $display("FAIL zero_sum_out got %0d want 0", so);
    end
    if (ol !== 1) begin
      n_err++; $display("FAIL zero_out_lat got %0d want 1", ol);
    end
    if (out_d !== '0) begin
      n_err++; $display("FAIL zero_out got %h want 0", out_d);
    end
    @(negedge clk);
  endtask

  task automatic test_extreme;
    logic [SUMW-1:0] so;
    logic [W-1:0] exp_o;
    int sl, ol;
`ifdef NORM_SAT_EN
    exp_o = row2(524287, -524288, 0);
`else
    exp_o = row2(-256, 256, 0);
`endif
    drive_row(row2(524287, -524287, 0), 1, so, sl, ol);
    n_cmp += 3;
    if (so !== '0) begin
      n_err++; $display("FAIL ext_sum_out got %0d want 0", so);
    end
    if (ol !== 225) begin
      n_err++; $display("FAIL ext_out_lat got %0d want 225", ol);
    end
    if (out_d !== exp_o) begin
      n_err++; $display("FAIL ext_out got %h want %h", out_d, exp_o);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [SUMW-1:0] so;
    logic [W-1:0] exp_o;
    int sl, ol;
    exp_o = row2(-256, 0, 0);
    out_ready = 1'b0;
    drive_row(row2(-30, 0, 0), 0, so, sl, ol);
    n_cmp += 3;
    if (so !== 24'd30) begin
      n_err++; $display("FAIL bp_sum_out got %0d want 30", so);
    end
    if (ol !== 225) begin
      n_err++; $display("FAIL bp_out_lat got %0d want 225", ol);
    end
    if (out_d !== exp_o) begin
      n_err++; $display("FAIL bp_out got %h want %h", out_d, exp_o);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_d = row2(7, 7, 7);
      in_valid = i[0];
      n_cmp += 3;
      if (out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold_ov got %b want 1", out_valid);
      end
      if (out_d !== exp_o) begin
        n_err++; $display("FAIL bp_hold_out got %h want %h", out_d, exp_o);
      end
      if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold_in_ready got %b want 0", in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp += 3;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_release_ov got %b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release_in_ready got %b want 1", in_ready);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release_busy got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [SUMW-1:0] so;
    logic [W-1:0] exp_o;
    int sl, ol;
    exp_o = row2(256, -128, 0);
    @(negedge clk);
    in_d = row2(100, -50, 0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    sum_in = 50;
    sum_in_valid = 1'b1;
    @(negedge clk);
    sum_in_valid = 1'b0;
    repeat (90) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ov got %b want 0", out_valid);
    end
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_busy got %b want 0", busy);
    end
    if (sum_out !== '0) begin
      n_err++; $display("FAIL mid_rst_sum_out got %0d want 0", sum_out);
    end
    if (out_d !== '0) begin
      n_err++; $display("FAIL mid_rst_out got %h want 0", out_d);
    end
    drive_row(row2(100, -50, 0), 50, so, sl, ol);
    n_cmp += 3;
    if (so !== 24'd50) begin
      n_err++; $display("FAIL mid_sum_out got %0d want 50", so);
    end
    if (ol !== 225) begin
      n_err++; $display("FAIL mid_out_lat got %0d want 225", ol);
    end
    if (out_d !== exp_o) begin
      n_err++; $display("FAIL mid_out got %h want %h", out_d, exp_o);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_d = '0;
    sum_in = '0;
    sum_in_valid = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_uniform();
    test_mixed();
    test_zero();
    test_extreme();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
